panda_risc_v_imem_fetch_queue: RTL
==================================

Name: panda_risc_v_imem_fetch_queue

Overview:
- Parametrised IFU fetch controller. Issues instruction-memory read requests, tracks up to OUTS_MAX in-flight/buffered fetches, and stores returned instructions in an OUTS_MAX-deep fetch-result FIFO.
- Stretches reset/flush requests until a redirect fetch is accepted, and discards stale responses.
- Sits between the PC-generation/branch-predict logic and the instruction bus control unit. Feeds the decode stage.

Parameters:
- OUTS_MAX, 4: max outstanding fetches (in-flight + buffered); power of 2, 2..8.
- PREDEC_W, 64: width of packed pre-decode message.
- simulation_delay, 1: NBA delay for simulation only.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- rst_req  in  1  reset redirect request (pulse)
- flush_req  in  1  flush redirect request (pulse)
- flush_addr  in  32  flush target
- to_rst  out  1  reset redirect in progress
- to_flush  out  1  flush redirect in progress
- flush_addr_hold  out  32  held flush target
- now_pc  out  32  PC of last accepted request
- new_pc  in  32  next fetch address (from PC gen)
- to_jump  in  1  predicted taken for now_inst
- now_inst  out  32  instruction presented to pre-decode
- predec_msg  in  PREDEC_W  pre-decode result
- illegal_inst  in  1  pre-decode illegal flag
- issue_hold  in  1  PC gen not ready (e.g. JALR base unread); blocks normal issue
- vld_inst_gotten  out  1  non-suppressed response this cycle
- imem_req_addr  out  32  = new_pc
- imem_req_valid  out  1
- imem_req_ready  in  1
- imem_resp_rdata  in  32
- imem_resp_err  in  2  00 ok, 01 misaligned, 10 bus err, 11 timeout
- imem_resp_valid  in  1
- if_res_pc  out  32
- if_res_inst  out  32
- if_res_predec  out  PREDEC_W
- if_res_msg  out  4  {to_jump, illegal, err[1:0]}
- if_res_valid  out  1
- if_res_ready  in  1
- outs_cnt  out  $clog2(OUTS_MAX)+1  outstanding count

Behaviour:
- Reset values: to_rst=0, to_flush=0, imem_req_valid=0, if_res_valid=0, vld_inst_gotten=0, outs_cnt=0. FIFO is empty; all pointers are 0; suppress flags are 0.
- Request accept: acc = imem_req_valid & imem_req_ready.
- Response pop: pop = if_res_valid & if_res_ready.
- Redirect pending flags:
  - rst_pend <= (rst_pend | rst_req) & ~acc.
  - flush_pend <= (flush_pend | flush_req) & ~acc.
  - to_rst = rst_req | rst_pend; to_flush = flush_req | flush_pend.
  - flush_addr latched on flush_req. flush_addr_hold = flush_pend ? latched : flush_addr.
- Common pending (cpend):
  - Set when vld_inst_gotten & ~acc and no rst/flush is active or pending.
  - Clears on acc, rst_req or flush_req.
  - now_inst = cpend ? latched rdata : imem_resp_rdata. rdata is latched on every imem_resp_valid.
- Request issue:
  - imem_req_valid = (outs_cnt < OUTS_MAX) & (to_rst | to_flush | ((vld_inst_gotten | cpend) & ~issue_hold)).
  - On acc: now_pc <= new_pc; PC queue (depth OUTS_MAX) pushes new_pc; suppress queue pushes 0.
- Outstanding counter: +1 on acc, -1 on pop, -1 on a suppressed response. Net sum is applied each cycle; the counter never exceeds OUTS_MAX and never underflows.
- Suppression:
  - rst_req|flush_req marks every in-flight (accepted, not yet responded) entry suppressed, including a response arriving in that same cycle.
  - The request accepted in the clear cycle is NOT suppressed.
  - vld_inst_gotten = imem_resp_valid & ~suppress[rptr] & ~(rst_req|flush_req).
  - Every imem_resp_valid advances the suppress/PC-queue read pointer.
- Fetch-result FIFO (depth OUTS_MAX):
  - Writes on vld_inst_gotten, storing {to_jump, illegal_inst, imem_resp_err, predec_msg, rdata, pc}.
  - Never full on a write; this is guaranteed by outs_cnt and asserted in simulation.
  - rst_req|flush_req empties the FIFO in the same cycle. if_res_valid is forced to 0 that cycle, and buffered entries are subtracted from outs_cnt.
- Pointers wrap modulo OUTS_MAX. Simultaneous push and pop on a full FIFO is legal.
- Reset mid-operation: all state returns to reset values. In-flight bus transactions are the bus unit's responsibility.

Test Plan:
- OUTS_MAX=4, ready always 1, rdata=PC+0x100: rst_req pulse with new_pc=0x0 -> request at 0x0; sequential fetches 0x0,0x4,0x8 appear on if_res in order with matching pc/inst and msg=4'b0000.
- if_res_ready=0, 6 responses offered -> outs_cnt saturates at 4 and imem_req_valid=0; one pop -> exactly one new request issues.
- Two requests in flight, flush_req with flush_addr=0x200 and imem_req_ready=0 for 3 cycles -> to_flush=1 and flush_addr_hold=0x200 held; both stale responses give vld_inst_gotten=0; first if_res pc=0x200.
- Flush in the same cycle as a response -> response discarded; FIFO empty next cycle; outs_cnt equals the remaining in-flight count.
- vld_inst_gotten with issue_hold=1 for 2 cycles, then resp rdata changes -> now_inst stays at the latched value; request issues the cycle issue_hold falls.
- imem_resp_err=2'b10, to_jump=1, illegal_inst=1 -> if_res_msg=4'b1110.

Source files
------------

// File: rtl/panda_risc_v_imem_fetch_queue_if.sv
// Bundles the fetch controller's instruction-memory request/response channel
// and its fetch-result channel toward decode.
interface panda_risc_v_imem_fetch_queue_if #(
  parameter int unsigned PREDEC_W = 64
);

  // instruction-memory request channel
  logic [31:0]         imem_req_addr;
  logic                imem_req_valid;
  logic                imem_req_ready;

  // instruction-memory response channel (in request order)
  logic [31:0]         imem_resp_rdata;
  logic [1:0]          imem_resp_err;
  logic                imem_resp_valid;

  // fetch-result channel toward decode
  logic [31:0]         if_res_pc;
  logic [31:0]         if_res_inst;
  logic [PREDEC_W-1:0] if_res_predec;
  logic [3:0]          if_res_msg;
  logic                if_res_valid;
  logic                if_res_ready;

  // fetch controller side
  modport master (
    output imem_req_addr,
    output imem_req_valid,
    input  imem_req_ready,
    input  imem_resp_rdata,
    input  imem_resp_err,
    input  imem_resp_valid,
    output if_res_pc,
    output if_res_inst,
    output if_res_predec,
    output if_res_msg,
    output if_res_valid,
    input  if_res_ready
  );

  // bus control unit / decode side
  modport slave (
    input  imem_req_addr,
    input  imem_req_valid,
    output imem_req_ready,
    output imem_resp_rdata,
    output imem_resp_err,
    output imem_resp_valid,
    input  if_res_pc,
    input  if_res_inst,
    input  if_res_predec,
    input  if_res_msg,
    input  if_res_valid,
    output if_res_ready
  );

endinterface

// File: rtl/panda_risc_v_imem_fetch_queue.sv
// IFU fetch controller: issues instruction fetches, bounds outstanding work to
// OUTS_MAX, discards responses made stale by reset/flush redirects and buffers
// good responses in a fetch-result FIFO for decode.
module panda_risc_v_imem_fetch_queue #(
  parameter int unsigned OUTS_MAX         = 4,
  parameter int unsigned PREDEC_W         = 64,
  parameter int          simulation_delay = 1
) (
  input  logic                       clk,
  input  logic                       resetn,

  input  logic                       rst_req,
  input  logic                       flush_req,
  input  logic [31:0]                flush_addr,
  output logic                       to_rst,
  output logic                       to_flush,
  output logic [31:0]                flush_addr_hold,

  output logic [31:0]                now_pc,
  input  logic [31:0]                new_pc,
  input  logic                       to_jump,
  output logic [31:0]                now_inst,
  input  logic [PREDEC_W-1:0]        predec_msg,
  input  logic                       illegal_inst,
  input  logic                       issue_hold,
  output logic                       vld_inst_gotten,

  output logic [$clog2(OUTS_MAX):0]  outs_cnt,

  panda_risc_v_imem_fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(OUTS_MAX);
  localparam int unsigned CW = AW + 1;

  // Elaboration-time parameter sanity check
  if (OUTS_MAX < 2 || OUTS_MAX > 8 || (OUTS_MAX & (OUTS_MAX - 1)) != 0 ||
      simulation_delay < 0) begin : g_param_chk
    $error("panda_risc_v_imem_fetch_queue: OUTS_MAX must be a power of 2 in 2..8");
  end

  typedef struct packed {
    logic                to_jump;
    logic                illegal;
    logic [1:0]          err;
    logic [PREDEC_W-1:0] predec;
    logic [31:0]         inst;
    logic [31:0]         pc;
  } fq_entry_t;

  // redirect stretching
  logic                r_rst_pend;
  logic                r_flush_pend;
  logic [31:0]         r_flush_addr;

  // common pending: a good instruction whose follow-on fetch is not yet accepted
  logic                r_cpend;
  logic [31:0]         r_rdata;

  // in-flight tracking (PC + suppress queue)
  logic [31:0]         r_now_pc;
  logic [31:0]         r_pcq [OUTS_MAX];
  logic [OUTS_MAX-1:0] r_supq;
  logic [AW-1:0]       r_pcq_wptr;
  logic [AW-1:0]       r_pcq_rptr;

  // fetch-result FIFO, pointers carry one wrap bit
  fq_entry_t           r_fifo [OUTS_MAX];
  logic [CW-1:0]       r_fifo_wptr;
  logic [CW-1:0]       r_fifo_rptr;

  logic [CW-1:0]       r_outs_cnt;

  logic                w_clr;
  logic                w_acc;
  logic                w_pop;
  logic                w_vld;
  logic                w_sup_resp;
  logic                w_req_valid;
  logic                w_res_valid;
  logic [CW-1:0]       w_fifo_cnt;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [CW-1:0]       w_cnt_nxt;
  fq_entry_t           w_wr_entry;
  fq_entry_t           w_rd_entry;

  assign w_clr        = rst_req | flush_req;
  assign w_acc        = w_req_valid & bus.imem_req_ready;

  assign w_fifo_cnt   = r_fifo_wptr - r_fifo_rptr;
  assign w_fifo_empty = (w_fifo_cnt == '0);
  assign w_fifo_full  = (w_fifo_cnt == CW'(OUTS_MAX));

  // A response is good unless its request predates a redirect
  assign w_vld        = bus.imem_resp_valid & ~r_supq[r_pcq_rptr] & ~w_clr;
  assign w_sup_resp   = bus.imem_resp_valid & ~w_vld;

  assign w_res_valid  = ~w_fifo_empty & ~w_clr;
  assign w_pop        = w_res_valid & bus.if_res_ready;

  assign to_rst          = rst_req | r_rst_pend;
  assign to_flush        = flush_req | r_flush_pend;
  assign flush_addr_hold = r_flush_pend ? r_flush_addr : flush_addr;

  // Redirects always issue; otherwise one fetch per received instruction
  assign w_req_valid = (r_outs_cnt < CW'(OUTS_MAX)) &
                       (to_rst | to_flush | ((w_vld | r_cpend) & ~issue_hold));

  assign now_inst        = r_cpend ? r_rdata : bus.imem_resp_rdata;
  assign now_pc          = r_now_pc;
  assign vld_inst_gotten = w_vld;
  assign outs_cnt        = r_outs_cnt;

  assign bus.imem_req_addr  = new_pc;
  assign bus.imem_req_valid = w_req_valid;

  assign w_rd_entry        = r_fifo[r_fifo_rptr[AW-1:0]];
  assign bus.if_res_valid  = w_res_valid;
  assign bus.if_res_pc     = w_rd_entry.pc;
  assign bus.if_res_inst   = w_rd_entry.inst;
  assign bus.if_res_predec = w_rd_entry.predec;
  assign bus.if_res_msg    = {w_rd_entry.to_jump, w_rd_entry.illegal, w_rd_entry.err};

  // Assemble the FIFO write payload from the current response and pre-decode
  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.to_jump = to_jump;
    w_wr_entry.illegal = illegal_inst;
    w_wr_entry.err     = bus.imem_resp_err;
    w_wr_entry.predec  = predec_msg;
    w_wr_entry.inst    = bus.imem_resp_rdata;
    w_wr_entry.pc      = r_pcq[r_pcq_rptr];
  end

  // Next outstanding count: new fetch in, popped or discarded work out
  always_comb begin
    w_cnt_nxt = r_outs_cnt + CW'(w_acc) - CW'(w_pop) - CW'(w_sup_resp);
    if (w_clr) begin
      w_cnt_nxt = w_cnt_nxt - w_fifo_cnt;
    end
  end

  // Hold reset/flush redirects until the redirect fetch is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_pend   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_flush_addr <= '0;
    end else begin
      r_rst_pend   <= (r_rst_pend | rst_req) & ~w_acc;
      r_flush_pend <= (r_flush_pend | flush_req) & ~w_acc;
      if (flush_req) begin
        r_flush_addr <= flush_addr;
      end
    end
  end

  // Keep the last response word and track an instruction awaiting its follow-on fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cpend <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (bus.imem_resp_valid) begin
        r_rdata <= bus.imem_resp_rdata;
      end
      if (w_vld & ~w_acc & ~to_rst & ~to_flush) begin
        r_cpend <= 1'b1;
      end else if (w_acc | w_clr) begin
        r_cpend <= 1'b0;
      end
    end
  end

  // PC and suppress queues for in-flight fetches; a redirect marks all older entries stale
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_now_pc   <= '0;
      r_pcq_wptr <= '0;
      r_pcq_rptr <= '0;
      r_supq     <= '0;
      for (int i = 0; i < int'(OUTS_MAX); i++) begin
        r_pcq[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_now_pc          <= new_pc;
        r_pcq[r_pcq_wptr] <= new_pc;
        r_pcq_wptr        <= r_pcq_wptr + AW'(1);
      end
      if (bus.imem_resp_valid) begin
        r_pcq_rptr <= r_pcq_rptr + AW'(1);
      end
      // slots outside the in-flight window are rewritten on push, so marking them is harmless
      for (int i = 0; i < int'(OUTS_MAX); i++) begin
        if (w_acc && (AW'(i) == r_pcq_wptr)) begin
          r_supq[i] <= 1'b0;
        end else if (w_clr) begin
          r_supq[i] <= 1'b1;
        end
      end
    end
  end

  // Fetch-result FIFO; a redirect empties it in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo_wptr <= '0;
      r_fifo_rptr <= '0;
      for (int i = 0; i < int'(OUTS_MAX); i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_vld) begin
        r_fifo[r_fifo_wptr[AW-1:0]] <= w_wr_entry;
        r_fifo_wptr                 <= r_fifo_wptr + CW'(1);
      end
      if (w_clr) begin
        r_fifo_rptr <= r_fifo_wptr;
      end else if (w_pop) begin
        r_fifo_rptr <= r_fifo_rptr + CW'(1);
      end
    end
  end

  // Outstanding fetch counter (in flight + buffered)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outs_cnt <= '0;
    end else begin
      r_outs_cnt <= w_cnt_nxt;
    end
  end

  // The outstanding limit guarantees room for every good response
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
                                  w_vld |-> (!w_fifo_full || w_pop))
    else $error("fetch-result FIFO written while full");

endmodule
